// File: rtl/mem_stage_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory requester.
// Holds the FSM encoding, size/rw pin values and the byte zero-extend helper.
package mem_stage_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/mem_stage_access_unit_counter.sv
// Loadable down-counter timing how long dm_enable stays high for one access.
// Holds at zero; zero flags the final access cycle.
module mem_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage requester for Data_Memory_RAM: issues one fixed-latency access per
// instruction, stalls the front end meanwhile, and rejects misaligned words.
import mem_stage_access_unit_pkg::*;

module mem_stage_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] dm_data_out,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  output logic              dm_size,
  output logic              dm_rw,
  output logic              dm_enable,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              stall,
  output logic              misaligned
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              size_q, rw_q, err_q, load_q;
  logic              legal, start, reject, last_beat;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;

  assign legal     = (mem_size == SIZE_BYTE) || (mem_addr[1:0] == 2'b00);
  assign start     = (state == IDLE) && mem_req && legal;
  assign reject    = (state == IDLE) && mem_req && !legal;
  assign last_beat = (state == ACCESS) && cnt_zero;

  mem_latency_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .load_value (CNT_INIT),
    .dec        ((state == ACCESS) && (cnt_value != '0)),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
               else if (reject) state_nxt = DONE;
      ACCESS:  if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // err_q/load_q describe the access that is retiring in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      rw_q    <= RW_READ;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      ld_data <= '0;
    end else begin
      if (start) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        size_q  <= mem_size;
        rw_q    <= mem_rw;
        err_q   <= 1'b0;
        load_q  <= 1'b0;
      end
      if (reject) begin
        err_q  <= 1'b1;
        load_q <= 1'b0;
      end
      if (last_beat && (rw_q == RW_READ)) begin
        ld_data <= (size_q == SIZE_WORD) ? dm_data_out : zext_byte(dm_data_out[7:0]);
        load_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    dm_enable  = (state == ACCESS);
    dm_address = dm_enable ? addr_q : '0;
    dm_size    = dm_enable ? size_q : SIZE_BYTE;
    dm_rw      = dm_enable ? rw_q : RW_READ;
    dm_data_in = '0;
    if (dm_enable)
      dm_data_in = (size_q == SIZE_WORD) ? wdata_q : zext_byte(wdata_q[7:0]);
    ld_valid   = (state == DONE) && load_q;
    misaligned = (state == DONE) && err_q;
    // reset gates stall so a held mem_req cannot freeze the front end during reset
    stall      = !reset && (((state == IDLE) && mem_req) || (state == ACCESS));
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: two instances (LATENCY 1 and 3) driven by
// directed vectors, corner-case sequences and random accesses.
module tb_mem_stage_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req, rw, size;
  logic [7:0]  addr [2];
  logic [31:0] wdata [2], rdata [2];
  logic [7:0]  dm_address [2];
  logic [31:0] dm_data_in [2], ld_data [2];
  logic [1:0]  dm_size, dm_rw, dm_enable, ld_valid, stall, misaligned;

  mem_stage_access_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .mem_req(req[0]), .mem_rw(rw[0]), .mem_size(size[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .dm_data_out(rdata[0]),
    .dm_address(dm_address[0]), .dm_data_in(dm_data_in[0]), .dm_size(dm_size[0]),
    .dm_rw(dm_rw[0]), .dm_enable(dm_enable[0]), .ld_data(ld_data[0]),
    .ld_valid(ld_valid[0]), .stall(stall[0]), .misaligned(misaligned[0])
  );

  mem_stage_access_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .mem_req(req[1]), .mem_rw(rw[1]), .mem_size(size[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .dm_data_out(rdata[1]),
    .dm_address(dm_address[1]), .dm_data_in(dm_data_in[1]), .dm_size(dm_size[1]),
    .dm_rw(dm_rw[1]), .dm_enable(dm_enable[1]), .ld_data(ld_data[1]),
    .ld_valid(ld_valid[1]), .stall(stall[1]), .misaligned(misaligned[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issues one access on instance k starting from IDLE at a negedge and
  // observes it through its DONE cycle; returns at the following negedge.
  task automatic do_access(input int k, input logic r, input logic s, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input bit keep_req,
                           output int st, output int en, output int lv, output int mi,
                           output int fbad, output logic [31:0] ld);
    logic [31:0] exp_din;
    bit fin;
    exp_din = s ? wd : {24'b0, wd[7:0]};
    st = 0; en = 0; lv = 0; mi = 0; fbad = 0; ld = '0; fin = 0;
    req[k] = 1'b1; rw[k] = r; size[k] = s; addr[k] = a; wdata[k] = wd; rdata[k] = rd;
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      if (stall[k]) st++;
      if (dm_enable[k]) begin
        en++;
        if (dm_address[k] !== a || dm_size[k] !== s || dm_rw[k] !== r || dm_data_in[k] !== exp_din)
          fbad++;
      end
      if (ld_valid[k]) lv++;
      if (misaligned[k]) mi++;
      if (!stall[k]) begin
        fin = 1;
        ld = ld_data[k];
        if (!keep_req) req[k] = 1'b0;
      end
      @(negedge clk);
    end
    if (!fin) chk("access_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int          k;
    logic        r;
    logic        s;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          e_st, e_en, e_lv, e_mi;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vt [7];

  initial begin
    int st, en, lv, mi, fbad;
    int lvc [2];
    int enc;
    logic [31:0] ld;
    logic [31:0] exp_ld [2];

    vt[0] = '{0, 1'b0, 1'b1, 8'h04, 32'h0,        32'hDEADBEEF, 2, 1, 1, 0, 32'hDEADBEEF};
    vt[1] = '{0, 1'b1, 1'b0, 8'h07, 32'h123456A5, 32'h0,        2, 1, 0, 0, 32'hDEADBEEF};
    vt[2] = '{1, 1'b0, 1'b0, 8'h03, 32'h0,        32'hFFFFFF80, 4, 3, 1, 0, 32'h00000080};
    vt[3] = '{1, 1'b1, 1'b1, 8'h02, 32'h87654321, 32'h0,        1, 0, 0, 1, 32'h00000080};
    vt[4] = '{0, 1'b0, 1'b1, 8'h01, 32'h0,        32'h11223344, 1, 0, 0, 1, 32'hDEADBEEF};
    vt[5] = '{1, 1'b0, 1'b1, 8'hFC, 32'h0,        32'hCAFEF00D, 4, 3, 1, 0, 32'hCAFEF00D};
    vt[6] = '{0, 1'b0, 1'b0, 8'hFF, 32'h0,        32'h00007F41, 2, 1, 1, 0, 32'h00000041};

    // reset held with mem_req high
    reset = 1'b1; req = 2'b11; rw = 2'b00; size = 2'b11;
    addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = '0; wdata[1] = '0;
    rdata[0] = 32'h11111111; rdata[1] = 32'h22222222;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", 32'(stall[k]), 32'd0);
      chk("rst_enable", 32'(dm_enable[k]), 32'd0);
      chk("rst_outs", 32'({ld_valid[k], misaligned[k], dm_size[k], dm_rw[k]}), 32'd0);
      chk("rst_addr", 32'(dm_address[k]), 32'd0);
      chk("rst_din", dm_data_in[k], 32'd0);
      chk("rst_ld_data", ld_data[k], 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_stall0", 32'(stall[0]), 32'd1);
    chk("post_rst_stall1", 32'(stall[1]), 32'd1);

    // mem_req dropped during ACCESS: latched word loads still complete
    @(negedge clk);
    req = 2'b00;
    lvc[0] = 0; lvc[1] = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) if (ld_valid[k]) lvc[k]++;
      @(negedge clk);
    end
    chk("drop_req_lv0", 32'(lvc[0]), 32'd1);
    chk("drop_req_lv1", 32'(lvc[1]), 32'd1);
    chk("drop_req_ld0", ld_data[0], 32'h11111111);
    chk("drop_req_ld1", ld_data[1], 32'h22222222);

    // reset in the second ACCESS cycle of the LATENCY=3 instance
    req[1] = 1'b1; rw[1] = 1'b0; size[1] = 1'b1; addr[1] = 8'h10; rdata[1] = 32'h55AA55AA;
    @(negedge clk);
    #1 chk("mid_acc1_enable", 32'(dm_enable[1]), 32'd1);
    @(negedge clk);
    reset = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_enable", 32'(dm_enable[1]), 32'd0);
    chk("mid_rst_stall", 32'(stall[1]), 32'd0);
    reset = 1'b0;
    lvc[1] = 0; enc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ld_valid[1]) lvc[1]++;
      if (dm_enable[1]) enc++;
      @(negedge clk);
    end
    chk("mid_rst_no_lv", 32'(lvc[1]), 32'd0);
    chk("mid_rst_no_en", 32'(enc), 32'd0);
    chk("mid_rst_ld_data", ld_data[1], 32'd0);

    // directed table
    foreach (vt[i]) begin
      do_access(vt[i].k, vt[i].r, vt[i].s, vt[i].a, vt[i].wd, vt[i].rd, 1'b0,
                st, en, lv, mi, fbad, ld);
      chk($sformatf("v%0d_stall_cycles", i), 32'(st), 32'(vt[i].e_st));
      chk($sformatf("v%0d_enable_cycles", i), 32'(en), 32'(vt[i].e_en));
      chk($sformatf("v%0d_ld_valid", i), 32'(lv), 32'(vt[i].e_lv));
      chk($sformatf("v%0d_misaligned", i), 32'(mi), 32'(vt[i].e_mi));
      chk($sformatf("v%0d_fields", i), 32'(fbad), 32'd0);
      chk($sformatf("v%0d_ld_data", i), ld, vt[i].e_ld);
    end
    exp_ld[0] = 32'h00000041;
    exp_ld[1] = 32'hCAFEF00D;

    // random accesses against a rule-level model; back-to-back when keep is set
    begin
      int k, nk, lat;
      bit keep, mis, r, s;
      logic [7:0] a;
      logic [31:0] wd, rd;
      nk = int'($urandom_range(0, 1));
      for (int i = 0; i < 40; i++) begin
        k  = nk;
        nk = int'($urandom_range(0, 1));
        keep = (i < 39) && (nk == k) && ($urandom_range(0, 1) == 1);
        r  = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        a  = 8'($urandom);
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        wd = $urandom;
        rd = $urandom;
        lat = (k == 0) ? 1 : 3;
        mis = s && (a[1:0] != 2'b00);
        if (!mis && !r) exp_ld[k] = s ? rd : (rd & 32'h000000FF);
        do_access(k, r, s, a, wd, rd, keep, st, en, lv, mi, fbad, ld);
        chk("rnd_stall_cycles", 32'(st), mis ? 32'd1 : 32'(lat + 1));
        chk("rnd_enable_cycles", 32'(en), mis ? 32'd0 : 32'(lat));
        chk("rnd_ld_valid", 32'(lv), (!mis && !r) ? 32'd1 : 32'd0);
        chk("rnd_misaligned", 32'(mi), mis ? 32'd1 : 32'd0);
        chk("rnd_fields", 32'(fbad), 32'd0);
        chk("rnd_ld_data", ld, exp_ld[k]);
      end
    end

    #1;
    chk("final_idle_enable", 32'(dm_enable), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Requester side of the data-memory interface: the MEM-stage initiator that drives the Data_Memory_RAM responder's address, data_in, size, rw and enable pins.
- Accepts one load/store per MEM-stage instruction, sequences a fixed-latency access, and returns zero-extended load data.
- Raises a stall that holds PC and IF/ID and selects the NOP path of the control multiplexer while an access is outstanding.
- Flags misaligned word accesses instead of issuing them.

Parameters:
- ADDR_W, 8, byte address width; matches the 8-bit data memory address.
- DATA_W, 32, data word width.
- LATENCY, 1, cycles dm_enable is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  MEM-stage memory enable; held high while stall is high
- mem_rw  in  1  1 = store, 0 = load
- mem_size  in  1  1 = word, 0 = byte
- mem_addr  in  ADDR_W  effective address from ALU
- mem_wdata  in  DATA_W  store data
- dm_data_out  in  DATA_W  read data from data memory
- dm_address  out  ADDR_W  address to data memory
- dm_data_in  out  DATA_W  write data to data memory
- dm_size  out  1  size to data memory, 1 = word
- dm_rw  out  1  rw to data memory, 1 = write
- dm_enable  out  1  data memory enable
- ld_data  out  DATA_W  load result for WB
- ld_valid  out  1  one-cycle pulse; ld_data is valid
- stall  out  1  hold PC/IF-ID and force NOP select
- misaligned  out  1  one-cycle pulse on a rejected word access

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high on port reset.
- Reset: state=IDLE, counter=0. All dm_* outputs, ld_data, ld_valid, stall and misaligned are 0. A reset mid-access aborts the access; dm_enable is 0 from the cycle after the reset edge, and no ld_valid is produced.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Drives dm_enable=0.
  - If mem_req=1 and the access is legal (byte, or word with mem_addr[1:0]=0): latch addr, wdata, size, rw; set counter=LATENCY-1; go to ACCESS.
  - If mem_req=1 and the access is a word with mem_addr[1:0]!=0: go to DONE with the error flag set. No memory access is issued.
- ACCESS:
  - dm_enable=1; dm_address, dm_size and dm_rw come from the latched values.
  - dm_data_in = latched wdata for word stores, {24'b0, wdata[7:0]} for byte stores.
  - Counter decrements each cycle. When counter=0 at the edge, a load captures ld_data (word: dm_data_out; byte: {24'b0, dm_data_out[7:0]}). Go to DONE.
- DONE:
  - dm_enable=0; stall=0. The pipeline advances at the end of DONE.
  - ld_valid=1 for a completed load; misaligned=1 if the error flag is set.
  - Unconditionally go to IDLE; a mem_req seen in DONE is the retiring instruction and is ignored.
- stall (combinational):
  - (state==IDLE & mem_req) | (state==ACCESS); 0 in DONE.
  - Cycles of stall per access = LATENCY+1. A misaligned access stalls 1 cycle.
- Store: ld_valid stays 0 and ld_data is unchanged.
- ld_data holds its value until the next completed load.
- Back-to-back requests: there is always at least one IDLE cycle between DONE and the next ACCESS.
- mem_req deasserting during ACCESS is ignored; the latched access completes.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - SIZE_BYTE=1'b0, SIZE_WORD=1'b1
  - RW_READ=1'b0, RW_WRITE=1'b1
  - byte zero-extend function
- Sub-module mem_latency_counter: loadable down-counter with load, value and zero outputs.

Test Plan:
- Reset held 2 cycles with mem_req=1 -> stall=0, dm_enable=0, all outputs 0; then reset=0 -> stall=1 in the following IDLE cycle.
- Word load, addr=8'h04, memory model returns 32'hDEADBEEF, LATENCY=1 -> dm_enable=1 for 1 cycle with dm_size=1, dm_rw=0; ld_valid pulses once with ld_data=32'hDEADBEEF; stall high exactly 2 cycles.
- Byte store, addr=8'h07, wdata=32'h123456A5 -> dm_data_in=32'h000000A5, dm_size=0, dm_rw=1; ld_valid never asserts.
- Byte load, addr=8'h03, dm_data_out=32'hFFFFFF80, LATENCY=3 -> dm_enable high 3 cycles; ld_data=32'h00000080; stall high 4 cycles.
- Word store to addr=8'h02 -> misaligned pulses 1 cycle, dm_enable stays 0, stall high 1 cycle.
- Reset asserted in the 2nd ACCESS cycle with LATENCY=3 -> FSM in IDLE after the edge, dm_enable=0, no ld_valid.
